// File: rtl/gato_pkg.sv
// Shared definitions for the tic-tac-toe cursor front end.
// Holds button indices, button count, FSM state type and priority helpers.
package gato_pkg;

    localparam int NUM_BTN = 5;
    localparam int IDX_W   = 3;

    // Button indices are listed in priority order: a lower index wins.
    localparam int BTN_ARRIBA    = 0;
    localparam int BTN_ABAJO     = 1;
    localparam int BTN_DERECHA   = 2;
    localparam int BTN_IZQUIERDA = 3;
    localparam int BTN_MARCAR    = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_GAP
    } estado_t;

    // Highest priority pending button (lowest index set).
    function automatic logic [IDX_W-1:0] prioridad(
        input logic [NUM_BTN-1:0] pend
    );
        prioridad = IDX_W'(BTN_MARCAR);
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pend[i]) prioridad = IDX_W'(i);
        end
    endfunction

    // Directions auto-repeat; marcar never does.
    function automatic logic es_direccion(input logic [IDX_W-1:0] idx);
        es_direccion = (idx != IDX_W'(BTN_MARCAR));
    endfunction

endpackage

// File: rtl/control_botones_antirrebote.sv
// antirrebote: 2-flop synchroniser plus debounce counter for one button.
// Ports: clk, reset (sync, active-high), raw in; level (debounced), rise (1-cycle strobe) out.
module antirrebote #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The counter only runs while the synchronised sample disagrees with
    // the accepted level; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                rise  <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/control_botones.sv
// control_botones: debounced, arbitrated, auto-repeating button commands.
// Ports: clk, reset, enable, five raw buttons in; five 1-cycle pulses and ocupado out.
module control_botones
    import gato_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int GAP_CYCLES      = 4,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic btn_arriba,
    input  logic btn_abajo,
    input  logic btn_derecha,
    input  logic btn_izquierda,
    input  logic btn_marcar,
    output logic arriba,
    output logic abajo,
    output logic derecha,
    output logic izquierda,
    output logic marcar,
    output logic ocupado
);

    localparam int GW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] rise;

    estado_t            state, state_next;
    logic [IDX_W-1:0]   sel, sel_next;
    logic [GW-1:0]      gap_cnt, gap_next;
    logic [NUM_BTN-1:0] pend, pend_next, pend_clr;

    logic               rpt_active, rpt_active_next;
    logic [IDX_W-1:0]   rpt_idx, rpt_idx_next;
    logic [RW-1:0]      rpt_cnt, rpt_cnt_next;
    logic [NUM_BTN-1:0] rpt_fire;

    logic [NUM_BTN-1:0] pulse;

    assign raw = {btn_marcar, btn_izquierda, btn_derecha, btn_abajo, btn_arriba};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        antirrebote #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .raw  (raw[i]),
            .level(level[i]),
            .rise (rise[i])
        );
    end

    // The last GAP cycle goes straight to EMIT when work is pending, so
    // back-to-back commands are spaced by exactly GAP_CYCLES low cycles.
    always_comb begin
        state_next = state;
        sel_next   = sel;
        gap_next   = gap_cnt;
        pend_clr   = '0;
        unique case (state)
            ST_IDLE: begin
                if (enable && |pend) begin
                    sel_next   = prioridad(pend);
                    state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                pend_clr   = NUM_BTN'(1) << sel;
                gap_next   = GW'(GAP_CYCLES - 1);
                state_next = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    if (enable && |pend) begin
                        sel_next   = prioridad(pend);
                        state_next = ST_EMIT;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    gap_next = gap_cnt - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Repeat timer. Firing sets pending one cycle before the pulse, hence
    // the delay load is REPEAT_DELAY-3 (emit cycle, fire cycle, idle check)
    // and the period reload is REPEAT_PERIOD-1.
    always_comb begin
        rpt_active_next = rpt_active;
        rpt_idx_next    = rpt_idx;
        rpt_cnt_next    = rpt_cnt;
        rpt_fire        = '0;
        if (rpt_active) begin
            if (!level[rpt_idx]) begin
                rpt_active_next = 1'b0;
                rpt_cnt_next    = '0;
            end else if (rpt_cnt == '0) begin
                rpt_fire     = NUM_BTN'(1) << rpt_idx;
                rpt_cnt_next = RW'(REPEAT_PERIOD - 1);
            end else begin
                rpt_cnt_next = rpt_cnt - 1'b1;
            end
        end
        // A repeat of the button already being timed keeps its cadence;
        // any other command restarts or stops the timer.
        if (state == ST_EMIT && !(rpt_active && rpt_idx == sel)) begin
            rpt_fire = '0;
            if (es_direccion(sel)) begin
                rpt_active_next = 1'b1;
                rpt_idx_next    = sel;
                rpt_cnt_next    = RW'(REPEAT_DELAY - 3);
            end else begin
                rpt_active_next = 1'b0;
                rpt_cnt_next    = '0;
            end
        end
        if (!enable) begin
            rpt_active_next = 1'b0;
            rpt_cnt_next    = '0;
            rpt_fire        = '0;
        end
    end

    assign pend_next = enable ? ((pend & ~pend_clr) | rise | rpt_fire) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            sel        <= '0;
            gap_cnt    <= '0;
            pend       <= '0;
            rpt_active <= 1'b0;
            rpt_idx    <= '0;
            rpt_cnt    <= '0;
        end else begin
            state      <= state_next;
            sel        <= sel_next;
            gap_cnt    <= gap_next;
            pend       <= pend_next;
            rpt_active <= rpt_active_next;
            rpt_idx    <= rpt_idx_next;
            rpt_cnt    <= rpt_cnt_next;
        end
    end

    assign pulse     = (state == ST_EMIT) ? (NUM_BTN'(1) << sel) : '0;
    assign arriba    = pulse[BTN_ARRIBA];
    assign abajo     = pulse[BTN_ABAJO];
    assign derecha   = pulse[BTN_DERECHA];
    assign izquierda = pulse[BTN_IZQUIERDA];
    assign marcar    = pulse[BTN_MARCAR];
    assign ocupado   = (state != ST_IDLE);

endmodule

// File: tb/tb_control_botones.sv
// Directed testbench for control_botones with short debounce/gap/repeat times.
// Each scenario task drives buttons and checks outputs cycle by cycle.
module tb_control_botones;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic btn_arriba = 1'b0;
    logic btn_abajo = 1'b0;
    logic btn_derecha = 1'b0;
    logic btn_izquierda = 1'b0;
    logic btn_marcar = 1'b0;
    logic arriba, abajo, derecha, izquierda, marcar, ocupado;

    int checks = 0;
    int errors = 0;

    wire [4:0] outs = {marcar, izquierda, derecha, abajo, arriba};

    control_botones #(
        .DEBOUNCE_CYCLES(4),
        .GAP_CYCLES     (2),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .btn_arriba   (btn_arriba),
        .btn_abajo    (btn_abajo),
        .btn_derecha  (btn_derecha),
        .btn_izquierda(btn_izquierda),
        .btn_marcar   (btn_marcar),
        .arriba       (arriba),
        .abajo        (abajo),
        .derecha      (derecha),
        .izquierda    (izquierda),
        .marcar       (marcar),
        .ocupado      (ocupado)
    );

    always #5 clk = ~clk;

    // bit 0 arriba .. bit 4 marcar
    task automatic set_btns(input logic [4:0] v);
        btn_arriba    = v[0];
        btn_abajo     = v[1];
        btn_derecha   = v[2];
        btn_izquierda = v[3];
        btn_marcar    = v[4];
    endtask

    task automatic settle(input int n);
        set_btns(5'b0);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (outs !== 5'b0 || ocupado !== 1'b0) begin
                errors++;
                $display("FAIL reset k=%0d outs=%b ocupado=%b expected 00000/0", k, outs, ocupado);
            end
            if (k == 2) reset = 1'b0;
        end
    endtask

    task automatic test_clean_press();
        logic [4:0] exp;
        @(negedge clk);
        set_btns(5'b00100);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            exp = (k == 7) ? 5'b00100 : 5'b00000;
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL clean_press k=%0d outs=%b expected=%b", k, outs, exp);
            end
            if (k == 9) set_btns(5'b0);
        end
        settle(20);
    endtask

    task automatic test_bounce();
        @(negedge clk);
        set_btns(5'b00001);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (outs !== 5'b0) begin
                errors++;
                $display("FAIL bounce k=%0d outs=%b expected=00000", k, outs);
            end
            if (k == 0) set_btns(5'b00000);
            if (k == 1) set_btns(5'b00001);
            if (k == 2) set_btns(5'b00000);
        end
        settle(10);
    endtask

    task automatic test_simultaneous();
        logic [4:0] exp;
        logic       exp_oc;
        @(negedge clk);
        set_btns(5'b01010);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            exp    = (k == 7) ? 5'b00010 : (k == 10) ? 5'b01000 : 5'b00000;
            exp_oc = (k >= 7 && k <= 12);
            checks++;
            if (outs !== exp || ocupado !== exp_oc) begin
                errors++;
                $display("FAIL simultaneous k=%0d outs=%b ocupado=%b expected=%b/%b",
                         k, outs, ocupado, exp, exp_oc);
            end
            if (k == 9) set_btns(5'b0);
        end
        settle(20);
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        @(negedge clk);
        set_btns(5'b00100);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            exp = (k == 7) ? 5'b00100 : (k == 10) ? 5'b10000 : 5'b00000;
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL back_to_back k=%0d outs=%b expected=%b", k, outs, exp);
            end
            if (k == 1) set_btns(5'b10100);
            if (k == 9) set_btns(5'b10000);
            if (k == 11) set_btns(5'b00000);
        end
        settle(20);
    endtask

    task automatic test_repeat();
        logic [4:0] exp;
        @(negedge clk);
        set_btns(5'b00001);
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            exp = (k == 7 || k == 27 || k == 35 || k == 43 || k == 51 || k == 59)
                  ? 5'b00001 : 5'b00000;
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL repeat_arriba k=%0d outs=%b expected=%b", k, outs, exp);
            end
            if (k == 59) set_btns(5'b0);
        end
        settle(10);
        set_btns(5'b10000);
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            exp = (k == 7) ? 5'b10000 : 5'b00000;
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL repeat_marcar k=%0d outs=%b expected=%b", k, outs, exp);
            end
            if (k == 59) set_btns(5'b0);
        end
        settle(10);
    endtask

    task automatic test_enable();
        @(negedge clk);
        enable = 1'b0;
        set_btns(5'b10000);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checks++;
            if (outs !== 5'b0) begin
                errors++;
                $display("FAIL enable k=%0d outs=%b expected=00000", k, outs);
            end
            if (k == 15) enable = 1'b1;
            if (k == 35) set_btns(5'b0);
        end
        enable = 1'b1;
        settle(20);
    endtask

    task automatic test_reset_emit();
        logic [4:0] exp;
        @(negedge clk);
        set_btns(5'b00100);
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            exp = (k == 7 || k == 16) ? 5'b00100 : 5'b00000;
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL reset_emit k=%0d outs=%b expected=%b", k, outs, exp);
            end
            if (k == 8) begin
                checks++;
                if (ocupado !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_emit_ocupado ocupado=%b expected=0", ocupado);
                end
                reset = 1'b0;
            end
            if (k == 7) reset = 1'b1;
            if (k == 22) set_btns(5'b0);
        end
        settle(20);
    endtask

    initial begin
        test_reset();
        settle(5);
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_back_to_back();
        test_repeat();
        test_enable();
        test_reset_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
